pipelined_segment_adder: RTL
============================

// Module: pipelined_segment_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit. Successor to the fixed 4-bit combinational
//  ripple adder. Splits a WIDTH-bit operation into WIDTH/SEG ripple segments, one register
//  stage per segment, so long carry chains close timing. Adds a valid/ready stream
//  interface, subtract mode, carry/borrow out and signed overflow. Sits between operand
//  sources and the datapath ALU result mux.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of SEG
//  SEG     4  bits resolved per pipeline stage; NST = WIDTH/SEG stages (latency)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      unit accepts beat this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add) / borrow-in, active high (sub)
//  sub        in   1      0: A+B+Cin   1: A-B-Cin
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result
//  Sum        out  WIDTH  result, modulo 2^WIDTH
//  Cout       out  1      add: carry out; sub: 1 = no borrow (A >= B+Cin unsigned)
//  Ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst=1 at edge): all stage valid bits 0, out_valid=0, Sum=0, Cout=0, Ovf=0;
//    in-flight beats are discarded. in_ready=1 in the first cycle after reset.
//  - Effective operands: Beff = sub ? ~B : B; c0 = sub ? ~Cin : Cin. Sum,Cout = A+Beff+c0.
//  - Ovf = (A[W-1] == Beff[W-1]) && (Sum[W-1] != A[W-1]).
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
//  - Handshake: input accepted iff in_valid && in_ready; output consumed iff
//    out_valid && out_ready. Sum/Cout/Ovf stable while out_valid && !out_ready.
//  - Stage k (0..NST-1), on adv: adds segment k of A/Beff with carry from stage k-1 reg
//    (stage 0 uses c0), stores its SEG result bits, carry, valid; upper unprocessed operand
//    segments and lower finished result segments shift forward with the beat (skew regs).
//  - Latency: exactly NST cycles from acceptance to out_valid when out_ready held high.
//    Throughput 1 beat/cycle. Bubbles (in_valid=0 while adv) propagate as valid=0.
//  - Backpressure: out_valid && !out_ready freezes the entire pipeline (no bubble collapse);
//    no beat is dropped, duplicated or reordered.
//  - Wrap-around: Sum wraps modulo 2^WIDTH; carry crossing every segment boundary is
//    carried by per-stage regs, never combinationally across stages.
//  - Simultaneous accept and consume in one cycle is legal and sustains full rate.
//  - Reset mid-stream overrides everything: rst wins over adv, in_valid, out_ready.
//  - X on A/B/Cin/sub while in_valid=0 must not affect any output.
// STRUCTURE
//  - Shared package adder_pkg: default WIDTH/SEG constants, NST function
//    (WIDTH/SEG), elaboration check that WIDTH % SEG == 0.
//  - One sub-module: rca_segment #(SEG) -- combinational SEG-bit ripple adder
//    (a, b, cin -> s, cout) built from a full-adder chain; instantiated NST times via generate.
//  - Top holds stage valid regs, carry regs, skew regs and the adv/handshake logic.
// TESTING  (WIDTH=16, SEG=4, latency 4)
//  1. A=0000 B=0000 Cin=0 sub=0, out_ready=1 -> 4 cycles later Sum=0000 Cout=0 Ovf=0.
//  2. A=FFFF B=0001 Cin=0 add -> Sum=0000 Cout=1 Ovf=0; A=7FFF B=0001 -> Sum=8000 Cout=0 Ovf=1.
//  3. sub: A=0003 B=0005 Cin=0 -> Sum=FFFE Cout=0 Ovf=0;
//     A=8000 B=0001 -> Sum=7FFF Cout=1 Ovf=1.
//  4. Stream 8 back-to-back beats (A=i, B=i, Cin=1), out_ready low cycles 5-7 ->
//     in_ready low those cycles, outputs 2i+1 in order, none lost, then 1/cycle.
//  5. rst asserted 2 cycles after 3 beats accepted -> next cycle out_valid=0, no stale
//     result ever appears; new beat A=0011 B=0111 add -> Sum=0122 after 4 cycles.
//  6. Random 10k beats with random in_valid/out_ready vs reference model; also run
//     WIDTH=8 SEG=8 (1-stage) and WIDTH=32 SEG=4.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and helpers for the segmented pipelined adder.
package adder_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    function automatic int nst(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit seg_ok(input int width, input int seg);
        return seg > 0 && width >= seg && width % seg == 0;
    endfunction
endpackage

// File: rtl/rca_segment.sv
// rca_segment: combinational SEG-bit ripple-carry adder built from a full-adder chain.
module rca_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    logic [SEG:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[SEG];
endmodule

// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder: WIDTH-bit add/sub resolved SEG bits per stage, valid/ready stream.
module pipelined_segment_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int NST = nst(WIDTH, SEG);

    if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipelined_segment_adder: WIDTH must be a positive multiple of SEG");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k consumes the lowest remaining operand segment and forwards the rest (skew regs).
    for (genvar k = 0; k < NST; k++) begin : g
        localparam int RW = WIDTH - k * SEG;
        logic [RW-1:0]          a_d, b_d;
        logic                   c_d, v_d;
        logic [SEG-1:0]         seg_s;
        logic                   seg_c;
        logic [(k+1)*SEG-1:0]   s_d, s_q;
        logic                   v_q, c_q;

        if (k == 0) begin : g_head
            // Gating with in_valid keeps idle-cycle X off the datapath.
            assign a_d = in_valid ? A : '0;
            assign b_d = in_valid ? (sub ? ~B : B) : '0;
            assign c_d = in_valid && (sub ^ Cin);
            assign v_d = in_valid;
            assign s_d = seg_s;
        end else begin : g_body
            assign a_d = g[k-1].g_skew.a_q;
            assign b_d = g[k-1].g_skew.b_q;
            assign c_d = g[k-1].c_q;
            assign v_d = g[k-1].v_q;
            assign s_d = {seg_s, g[k-1].s_q};
        end

        rca_segment #(.SEG(SEG)) u_rca (
            .a    (a_d[SEG-1:0]),
            .b    (b_d[SEG-1:0]),
            .cin  (c_d),
            .s    (seg_s),
            .cout (seg_c)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= seg_c;
                s_q <= s_d;
            end
        end

        if (k < NST - 1) begin : g_skew
            logic [RW-SEG-1:0] a_q, b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d[RW-1:SEG];
                    b_q <= b_d[RW-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst) ovf_q <= 1'b0;
                else if (adv) ovf_q <= (a_d[RW-1] == b_d[RW-1]) && (seg_s[SEG-1] != a_d[RW-1]);
            end
        end
    end

    assign out_valid = g[NST-1].v_q;
    assign Sum       = g[NST-1].s_q;
    assign Cout      = g[NST-1].c_q;
    assign Ovf       = g[NST-1].g_tail.ovf_q;
endmodule
